// File: rtl/reg_file_mp.sv
// Register file with one write port and two registered read ports.
// Write-first bypass, optional hardwired zero register, and a counter-driven zeroing pass after reset.
//
// state  | meaning
// S_INIT | clearing mem[cnt] each cycle, ports ignored, ready=0
// S_RUN  | ready=1, reads and writes accepted every cycle
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  // Array is sized to the full address space so every index is legal;
  // entries at or above DEPTH are never written and never read back.
  localparam int                MEM_N   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] mem_q [MEM_N];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic wa_drop, ra1_zero, ra2_zero;
  logic wr_ok, rd_acc;

  assign wa_drop  = (ZERO_REG && (wa  == '0)) || ({1'b0, wa}  >= DEPTH_X);
  assign ra1_zero = (ZERO_REG && (ra1 == '0)) || ({1'b0, ra1} >= DEPTH_X);
  assign ra2_zero = (ZERO_REG && (ra2 == '0)) || ({1'b0, ra2} >= DEPTH_X);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = wa;
    mem_wd     = wd;
    wr_ok      = 1'b0;
    rd_acc     = 1'b0;

    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = S_RUN;
      end
      S_RUN: begin
        wr_ok  = we && !wa_drop;
        mem_we = wr_ok;
        rd_acc = rd_en;
      end
      default: state_d = S_INIT;
    endcase

    if (rd_acc) begin
      rd_valid_d = 1'b1;
      if (ra1_zero)                  rd1_d = '0;
      else if (wr_ok && (wa == ra1)) rd1_d = wd;
      else                           rd1_d = mem_q[ra1];
      if (ra2_zero)                  rd2_d = '0;
      else if (wr_ok && (wa == ra2)) rd2_d = wd;
      else                           rd2_d = mem_q[ra2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage carries no reset; the INIT pass establishes its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign ready    = (state_q == S_RUN);
  assign rd1      = rd1_q;
  assign rd2      = rd2_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: dut_a is DEPTH=32 with ZERO_REG=1, dut_b is DEPTH=20 with ZERO_REG=0.
// Both share the port stimulus and clock; each has its own reset.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        rd_en, we;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;

  logic        ready_a, rd_valid_a, ready_b, rd_valid_b;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .ready(ready_a), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_a), .rd2(rd2_a), .rd_valid(rd_valid_a), .we(we), .wa(wa), .wd(wd)
  );

  reg_file_mp #(.DATA_W(32), .DEPTH(20), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .ready(ready_b), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_b), .rd2(rd2_b), .rd_valid(rd_valid_b), .we(we), .wa(wa), .wd(wd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; we = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0;
  endtask

  task automatic test_reset();
    logic exp_rdy;
    idle();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    tick();
    n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_a); end
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_a); end
    n_cmp++; if (rd1_a !== 32'h0) begin n_err++; $display("FAIL reset_rd1: got %h want 0", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h0) begin n_err++; $display("FAIL reset_rd2: got %h want 0", rd2_a); end
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_rdy = (i == 31);
      n_cmp++;
      if (ready_a !== exp_rdy) begin
        n_err++; $display("FAIL init_ready_a edge %0d: got %b want %b", i, ready_a, exp_rdy);
      end
      if (i == 18 || i == 19) begin
        exp_rdy = (i == 19);
        n_cmp++;
        if (ready_b !== exp_rdy) begin
          n_err++; $display("FAIL init_ready_b edge %0d: got %b want %b", i, ready_b, exp_rdy);
        end
      end
    end
  endtask

  task automatic test_read_after_init();
    rd_en = 1'b1; ra1 = 5'd5; ra2 = 5'd31;
    tick();
    n_cmp++; if (rd1_a !== 32'h0) begin n_err++; $display("FAIL init_read_rd1: got %h want 0", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h0) begin n_err++; $display("FAIL init_read_rd2: got %h want 0", rd2_a); end
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_err++; $display("FAIL init_read_valid: got %b want 1", rd_valid_a); end
    idle();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd3; wd = 32'h8C12_3456;
    tick();
    we = 1'b0; rd_en = 1'b1; ra1 = 5'd3; ra2 = 5'd5;
    tick();
    n_cmp++; if (rd1_a !== 32'h8C12_3456) begin n_err++; $display("FAIL write_read_rd1: got %h want 8c123456", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h0) begin n_err++; $display("FAIL write_read_rd2: got %h want 0", rd2_a); end
    rd_en = 1'b0;
    tick();
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", rd_valid_a); end
    n_cmp++; if (rd1_a !== 32'h8C12_3456) begin n_err++; $display("FAIL idle_hold_rd1: got %h want 8c123456", rd1_a); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd7; wd = 32'h1301_2345; rd_en = 1'b1; ra1 = 5'd7; ra2 = 5'd7;
    tick();
    n_cmp++; if (rd1_a !== 32'h1301_2345) begin n_err++; $display("FAIL bypass_rd1: got %h want 13012345", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h1301_2345) begin n_err++; $display("FAIL bypass_rd2: got %h want 13012345", rd2_a); end
    wd = 32'h0000_55AA; ra2 = 5'd3;
    tick();
    n_cmp++; if (rd1_a !== 32'h0000_55AA) begin n_err++; $display("FAIL b2b_rd1: got %h want 000055aa", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h8C12_3456) begin n_err++; $display("FAIL b2b_rd2: got %h want 8c123456", rd2_a); end
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", rd_valid_a); end
    idle();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    tick();
    we = 1'b0; rd_en = 1'b1; ra1 = 5'd0; ra2 = 5'd0;
    tick();
    n_cmp++; if (rd1_a !== 32'h0) begin n_err++; $display("FAIL zero_reg_a_rd1: got %h want 0", rd1_a); end
    n_cmp++; if (rd1_b !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL zero_reg_b_rd1: got %h want ffffffff", rd1_b); end
    we = 1'b1; wd = 32'h0F0F_0F0F;
    tick();
    n_cmp++; if (rd2_a !== 32'h0) begin n_err++; $display("FAIL zero_bypass_a_rd2: got %h want 0", rd2_a); end
    n_cmp++; if (rd2_b !== 32'h0F0F_0F0F) begin n_err++; $display("FAIL zero_bypass_b_rd2: got %h want 0f0f0f0f", rd2_b); end
    idle();
  endtask

  task automatic test_depth();
    we = 1'b1; wa = 5'd25; wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; rd_en = 1'b1; ra1 = 5'd25; ra2 = 5'd19;
    tick();
    n_cmp++; if (rd1_b !== 32'h0) begin n_err++; $display("FAIL oor_read_b: got %h want 0", rd1_b); end
    n_cmp++; if (rd2_b !== 32'h0) begin n_err++; $display("FAIL last_reg_b_init: got %h want 0", rd2_b); end
    n_cmp++; if (rd1_a !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL inrange_a_25: got %h want deadbeef", rd1_a); end
    we = 1'b1; wa = 5'd25; wd = 32'h1234_5678; ra2 = 5'd25;
    tick();
    n_cmp++; if (rd2_b !== 32'h0) begin n_err++; $display("FAIL oor_bypass_b: got %h want 0", rd2_b); end
    n_cmp++; if (rd2_a !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_a_25: got %h want 12345678", rd2_a); end
    rd_en = 1'b0; wa = 5'd19; wd = 32'hAD65_4321;
    tick();
    we = 1'b0; rd_en = 1'b1; ra1 = 5'd19; ra2 = 5'd19;
    tick();
    n_cmp++; if (rd1_b !== 32'hAD65_4321) begin n_err++; $display("FAIL last_reg_b_rd1: got %h want ad654321", rd1_b); end
    n_cmp++; if (rd2_b !== 32'hAD65_4321) begin n_err++; $display("FAIL last_reg_b_rd2: got %h want ad654321", rd2_b); end
    n_cmp++; if (rd1_a !== 32'hAD65_4321) begin n_err++; $display("FAIL reg19_a_rd1: got %h want ad654321", rd1_a); end
  endtask

  task automatic test_mid_reset();
    #2;
    rst_a = 1'b0;
    #1;
    n_cmp++; if (rd1_a !== 32'h0) begin n_err++; $display("FAIL async_rst_rd1: got %h want 0", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h0) begin n_err++; $display("FAIL async_rst_rd2: got %h want 0", rd2_a); end
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", rd_valid_a); end
    n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL async_rst_ready: got %b want 0", ready_a); end
    tick();
    rst_a = 1'b1;
    we = 1'b1; wa = 5'd19; wd = 32'hFFFF_FFFF; rd_en = 1'b1; ra1 = 5'd19; ra2 = 5'd19;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++;
      if (rd_valid_a !== 1'b0) begin
        n_err++; $display("FAIL reinit_valid edge %0d: got %b want 0", i, rd_valid_a);
      end
    end
    n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL reinit_ready: got %b want 1", ready_a); end
    we = 1'b0; ra1 = 5'd19; ra2 = 5'd3;
    tick();
    n_cmp++; if (rd1_a !== 32'h0) begin n_err++; $display("FAIL reinit_rd1: got %h want 0", rd1_a); end
    n_cmp++; if (rd2_a !== 32'h0) begin n_err++; $display("FAIL reinit_rd2: got %h want 0", rd2_a); end
    n_cmp++; if (rd_valid_a !== 1'b1) begin n_err++; $display("FAIL reinit_read_valid: got %b want 1", rd_valid_a); end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_after_init();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_depth();
    test_mid_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised register file for the datapath: one write port and two read ports with registered read data and write-to-read bypass. It allows a read and a write in the same cycle, and zeroes its whole array through a counter-driven init sequence after reset. It sits between the decode stage and the ALU operand registers and is sized by parameter for any register count and word width.

## Interface
- DATA_W, 32, word width in bits
- DEPTH, 32, number of registers (2..256, not required to be a power of two)
- ADDR_W, $clog2(DEPTH), address width
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  asynchronous, active-low reset
- ready  output  1  high when init is complete and ports are accepted
- rd_en  input  1  read request, samples ra1/ra2
- ra1  input  ADDR_W  read address, port 1
- ra2  input  ADDR_W  read address, port 2
- rd1  output  DATA_W  registered read data, port 1
- rd2  output  DATA_W  registered read data, port 2
- rd_valid  output  1  rd1/rd2 updated by the previous cycle's accepted read
- we  input  1  write enable
- wa  input  ADDR_W  write address
- wd  input  DATA_W  write data

## Operation
- States: INIT and RUN. Reset (rst=0) forces INIT asynchronously and sets init counter=0, ready=0, rd_valid=0, rd1=0, rd2=0.
- INIT: each cycle writes 0 to mem[counter], then increments the counter. On the cycle counter==DEPTH-1 the FSM moves to RUN. rd_en and we are ignored in INIT, with no side effects.
- RUN: ready=1. Stays in RUN until the next reset.
- Write (RUN, we=1): mem[wa]<=wd at the clock edge.
  - Ignored if ZERO_REG=1 and wa==0.
  - Ignored if wa>=DEPTH.
- Read (RUN, rd_en=1): on each port, rdN<=value, where value is selected in this priority order:
  - 0 if raN>=DEPTH, or if ZERO_REG=1 and raN==0;
  - wd if we=1 and wa==raN and the write is not ignored (write-first bypass);
  - otherwise mem[raN].
- On a read, rd_valid<=1. When rd_en=0 or not RUN, rd_valid<=0 and rd1/rd2 hold their last values.
- Both ports may address the same register, including the register being written; both return identical data.
- Reset asserted mid-INIT or mid-RUN aborts immediately. Array contents are not guaranteed until the next INIT completes.

## Timing
- Reset deassert at edge 0: INIT runs for DEPTH cycles and ready=1 from edge DEPTH onward.
- Read latency is 1 cycle: address on edge k, data and rd_valid visible after edge k+1.
- Write latency: a write on edge k is visible to a read sampled on edge k (bypass) and on every later edge.
- rd_en and we may both be asserted every cycle. There is no back-pressure in RUN.
- Reset is asynchronous assert. Deassertion is assumed synchronised upstream.

## Test plan
- Reset release, DEPTH=32 -> ready=0 for 32 cycles, ready=1 at cycle 32; reads of ra1=5, ra2=31 return 0/0 with rd_valid=1 the next cycle.
- Write wa=3 wd=0x8C123456, then read ra1=3 next cycle -> rd1=0x8C123456 one cycle after the read.
- Same cycle: we=1 wa=7 wd=0x13012345, rd_en=1 ra1=7 ra2=7 -> rd1=rd2=0x13012345 (bypass).
- ZERO_REG=1: write wa=0 wd=0xFFFFFFFF, then read ra1=0 -> rd1=0. ZERO_REG=0, same stimulus -> rd1=0xFFFFFFFF.
- DEPTH=20: write wa=25 is dropped, and a read of ra1=25 returns 0. Write wa=19 wd=0xAD654321 then read -> 0xAD654321.
- Assert rst mid-RUN while rd1=0xAD654321 -> rd1=rd2=0 and rd_valid=0 immediately. INIT re-runs for DEPTH cycles; we pulses during INIT are dropped, and the register read afterwards returns 0.
